// File: rtl/phoenix_switch_control.sv
// phoenix_switch_control
//   Switch allocator for a 5-port XY-routed mesh router.
//   One FSM (IDLE -> ARB -> ROUTE -> ACK) serves header requests.
//     ARB   : picks an input round-robin.
//     ROUTE : computes the XY destination from that input's head flit.
//     ACK   : grants the header and records the crossbar connection.
//   A falling i_sender edge on a connected input tears its connection down.
//
//   Optional build macro: PHOENIX_SC_LOCAL_PRIO_EN
//     When defined, a pending LOCAL header always wins arbitration.
//     Round-robin then applies only among the four mesh ports.
//
// Parameters
//   FLIT_W   flit width in bits (>= 8; the routing target is in bits [7:0])
//   ADDRESS  router address, x = ADDRESS[7:4], y = ADDRESS[3:0]
//
// Ports (port index order EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4)
//   i_clk      clock
//   i_rst      synchronous reset, active low
//   i_h        header-pending request per input buffer
//   i_sender   input buffer currently transmitting a packet
//   i_data     head flit per input, port p at [p*FLIT_W +: FLIT_W]
//   o_ack_h    one-cycle header grant per input
//   o_free     output port unallocated
//   o_mux_in   input index feeding output o at [3*o +: 3], 7 = none
//   o_mux_out  output index fed by input i at [3*i +: 3], 7 = none
module phoenix_switch_control #(
    parameter int         FLIT_W  = 16,
    parameter logic [7:0] ADDRESS = 8'h11
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [4:0]            i_h,
    input  logic [4:0]            i_sender,
    input  logic [5*FLIT_W-1:0]   i_data,
    output logic [4:0]            o_ack_h,
    output logic [4:0]            o_free,
    output logic [14:0]           o_mux_in,
    output logic [14:0]           o_mux_out
);

    localparam logic [3:0] MY_X  = ADDRESS[7:4];
    localparam logic [3:0] MY_Y  = ADDRESS[3:0];
    localparam logic [2:0] EAST  = 3'd0;
    localparam logic [2:0] WEST  = 3'd1;
    localparam logic [2:0] NORTH = 3'd2;
    localparam logic [2:0] SOUTH = 3'd3;
    localparam logic [2:0] LOCAL = 3'd4;
    localparam logic [2:0] NONE  = 3'd7;

    typedef enum logic [1:0] {IDLE, ARB, ROUTE, ACK} state_t;

    state_t       state_q, state_d;
    logic [2:0]   sel_q, dest_q;
    logic [2:0]   arb_sel, route_dest;
    logic         route_ok;
    logic [7:0]   head;
    logic [4:0]   sender_q;
    logic [4:0]   rel_in, rel_out;
    logic [4:0]   free_q;
    logic [14:0]  mux_in_q, mux_out_q;

    // Payload bits above the routing byte do not influence allocation.
    logic unused_flit_bits;
    assign unused_flit_bits = ^i_data;

    // First requester strictly after 'last', wrapping modulo 5.
    function automatic logic [2:0] rr_next(input logic [4:0] req, input logic [2:0] last);
        logic [2:0] pick;
        logic       found;
        int         p;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            p = (int'(last) + k) % 5;
            if (!found && req[p]) begin
                pick  = 3'(p);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
`ifdef PHOENIX_SC_LOCAL_PRIO_EN
        // LOCAL pre-empts; otherwise i_h[4]=0 so the search only sees mesh ports.
        arb_sel = i_h[4] ? LOCAL : rr_next(i_h, sel_q);
`else
        arb_sel = rr_next(i_h, sel_q);
`endif
    end

    // Head flit of the selected input.
    always_comb begin
        head = '0;
        for (int p = 0; p < 5; p++) begin
            if (sel_q == 3'(p)) head = i_data[p*FLIT_W +: 8];
        end
    end

    // XY routing: resolve X first, then Y.
    always_comb begin
        if (head[7:4] > MY_X)      route_dest = EAST;
        else if (head[7:4] < MY_X) route_dest = WEST;
        else if (head[3:0] > MY_Y) route_dest = NORTH;
        else if (head[3:0] < MY_Y) route_dest = SOUTH;
        else                       route_dest = LOCAL;
    end

    // Falling i_sender on a connected input releases its output this cycle.
    always_comb begin
        rel_in  = '0;
        rel_out = '0;
        for (int i = 0; i < 5; i++) begin
            if (sender_q[i] && !i_sender[i] && mux_out_q[3*i +: 3] != NONE) begin
                rel_in[i] = 1'b1;
                for (int o = 0; o < 5; o++) begin
                    if (mux_out_q[3*i +: 3] == 3'(o)) rel_out[o] = 1'b1;
                end
            end
        end
    end

    // An output being released this cycle is still treated as busy, and a
    // mesh input may never be routed back out of its own port.
    always_comb begin
        route_ok = 1'b0;
        for (int o = 0; o < 5; o++) begin
            if (route_dest == 3'(o)) route_ok = free_q[o] && !rel_out[o];
        end
        if (route_dest == sel_q && sel_q != LOCAL) route_ok = 1'b0;
    end

    // FSM: state register
    always_ff @(posedge i_clk) begin
        if (!i_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|i_h) state_d = ARB;
            ARB:     state_d = (|i_h) ? ROUTE : IDLE;
            ROUTE:   state_d = route_ok ? ACK : IDLE;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_ack_h = '0;
        for (int p = 0; p < 5; p++) begin
            o_ack_h[p] = (state_q == ACK) && (sel_q == 3'(p));
        end
    end

    // Selection and crossbar allocation. Release is applied before the ACK
    // allocation so that a grant on the same input wins its own mux_out entry.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            sel_q     <= LOCAL;
            dest_q    <= NONE;
            sender_q  <= '0;
            free_q    <= '1;
            mux_in_q  <= '1;
            mux_out_q <= '1;
        end else begin
            sender_q <= i_sender;
            if (state_q == ARB && |i_h) sel_q  <= arb_sel;
            if (state_q == ROUTE)       dest_q <= route_dest;
            for (int i = 0; i < 5; i++) begin
                if (rel_in[i]) mux_out_q[3*i +: 3] <= NONE;
                if (rel_out[i]) begin
                    free_q[i]          <= 1'b1;
                    mux_in_q[3*i +: 3] <= NONE;
                end
            end
            if (state_q == ACK) begin
                for (int p = 0; p < 5; p++) begin
                    if (dest_q == 3'(p)) begin
                        free_q[p]          <= 1'b0;
                        mux_in_q[3*p +: 3] <= sel_q;
                    end
                    if (sel_q == 3'(p)) mux_out_q[3*p +: 3] <= dest_q;
                end
            end
        end
    end

    assign o_free    = free_q;
    assign o_mux_in  = mux_in_q;
    assign o_mux_out = mux_out_q;

endmodule

// File: tb/tb_phoenix_switch_control.sv
module tb_phoenix_switch_control;

    localparam int         FLIT_W = 16;
    localparam logic [7:0] ADDR   = 8'h11;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic [4:0]           i_h;
    logic [4:0]           i_sender;
    logic [5*FLIT_W-1:0]  i_data;
    logic [4:0]           o_ack_h;
    logic [4:0]           o_free;
    logic [14:0]          o_mux_in;
    logic [14:0]          o_mux_out;

    phoenix_switch_control #(.FLIT_W(FLIT_W), .ADDRESS(ADDR)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_h      (i_h),
        .i_sender (i_sender),
        .i_data   (i_data),
        .o_ack_h  (o_ack_h),
        .o_free   (o_free),
        .o_mux_in (o_mux_in),
        .o_mux_out(o_mux_out)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Connections held as plain arrays; an arbitration attempt is tracked by
    // how many cycles it has been in flight (0 = no attempt).
    int       m_out[5];   // output used by input i, -1 none
    int       m_in[5];    // input holding output o, -1 none
    int       m_last;
    int       m_age;
    int       m_port;
    int       m_dest;
    bit [4:0] m_prev_s;

    task automatic model_reset();
        for (int k = 0; k < 5; k++) begin
            m_out[k] = -1;
            m_in[k]  = -1;
        end
        m_last   = 4;
        m_age    = 0;
        m_port   = 0;
        m_dest   = 0;
        m_prev_s = '0;
    endtask

    function automatic int pick(input logic [4:0] h, input int last);
`ifdef PHOENIX_SC_LOCAL_PRIO_EN
        if (h[4]) return 4;
`endif
        for (int k = 1; k <= 5; k++) if (h[(last + k) % 5]) return (last + k) % 5;
        return last;
    endfunction

    function automatic int xy_dest(input logic [7:0] f);
        int tx, ty, x, y;
        tx = int'(f[7:4]); ty = int'(f[3:0]);
        x  = int'(ADDR[7:4]); y = int'(ADDR[3:0]);
        if (tx > x) return 0;
        if (tx < x) return 1;
        if (ty > y) return 2;
        if (ty < y) return 3;
        return 4;
    endfunction

    task automatic model_step();
        bit [4:0]   released;
        logic [7:0] f;
        released = '0;
        if (!i_rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 5; i++) begin
            if (m_prev_s[i] && !i_sender[i] && m_out[i] >= 0) begin
                released[m_out[i]] = 1'b1;
                m_in[m_out[i]] = -1;
                m_out[i] = -1;
            end
        end
        case (m_age)
            0: if (i_h != 0) m_age = 1;
            1: begin
                if (i_h != 0) begin
                    m_port = pick(i_h, m_last);
                    m_last = m_port;
                    m_age  = 2;
                end else m_age = 0;
            end
            2: begin
                f      = i_data[m_port*FLIT_W +: 8];
                m_dest = xy_dest(f);
                if (m_in[m_dest] < 0 && !released[m_dest] && !(m_dest == m_port && m_port != 4))
                    m_age = 3;
                else
                    m_age = 0;
            end
            default: begin
                m_out[m_port] = m_dest;
                m_in[m_dest]  = m_port;
                m_age = 0;
            end
        endcase
        m_prev_s = i_sender;
    endtask

    task automatic compare_all();
        logic [4:0]  e_ack, e_free;
        logic [14:0] e_in, e_out;
        e_ack = (m_age == 3) ? 5'(1 << m_port) : 5'd0;
        for (int k = 0; k < 5; k++) begin
            e_free[k]      = (m_in[k] < 0);
            e_in[3*k +: 3] = (m_in[k] < 0) ? 3'd7 : 3'(m_in[k]);
            e_out[3*k +: 3] = (m_out[k] < 0) ? 3'd7 : 3'(m_out[k]);
        end
        chk("ack", o_ack_h, e_ack);
        chk("ack_onehot", ($countones(o_ack_h) <= 1), 1);
        chk("free", o_free, e_free);
        chk("mux_in", o_mux_in, e_in);
        chk("mux_out", o_mux_out, e_out);
    endtask

    // One clock: model and DUT see the same inputs at the edge; outputs are
    // sampled 1 time unit later.
    task automatic tick();
        @(posedge i_clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic wait_ack(input string tag, input logic [4:0] exp, input int budget);
        int n = 0;
        while (o_ack_h == 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, o_ack_h, exp);
    endtask

    task automatic do_reset();
        i_rst = 1'b0; i_h = '0; i_sender = '0;
        tick(); tick();
        i_rst = 1'b1;
    endtask

    task automatic set_flit(input int p, input logic [7:0] tgt);
        i_data[p*FLIT_W +: FLIT_W] = {8'h00, tgt};
    endtask

    logic [4:0] acc;

    initial begin
        i_rst = 1'b0; i_h = '0; i_sender = '0; i_data = '0;
        model_reset();

        // reset state
        do_reset();
        chk("rst_free", o_free, 5'b11111);
        chk("rst_mux_in", o_mux_in, 15'h7fff);
        chk("rst_mux_out", o_mux_out, 15'h7fff);
        chk("rst_ack", o_ack_h, 5'b0);

        // single route: LOCAL -> EAST, exact 3-cycle latency
        set_flit(4, 8'h31);
        i_h = 5'b10000;
        tick(); tick(); tick();
        chk("single_ack", o_ack_h, 5'b10000);
        i_h = '0; i_sender = 5'b10000;
        tick();
        chk("single_free_e", o_free[0], 1'b0);
        chk("single_mux_in_e", o_mux_in[2:0], 3'd4);
        chk("single_mux_out_l", o_mux_out[14:12], 3'd0);
        tick(); tick();

        // release
        i_sender = '0;
        tick();
        chk("release_free", o_free, 5'b11111);
        chk("release_mux_in", o_mux_in, 15'h7fff);
        chk("release_mux_out", o_mux_out, 15'h7fff);

        // fairness: EAST then WEST
        do_reset();
        set_flit(0, 8'h11); set_flit(1, 8'h12);
        i_h = 5'b00011;
        wait_ack("fair_first", 5'b00001, 6);
        i_h = 5'b00010;
        tick();
        wait_ack("fair_second", 5'b00010, 8);
        i_h = '0;
        tick();
        chk("fair_mux_in_n", o_mux_in[8:6], 3'd1);

        // contention: EAST holds SOUTH, WEST wants SOUTH
        do_reset();
        set_flit(0, 8'h10);
        i_h = 5'b00001;
        wait_ack("cont_east", 5'b00001, 6);
        i_h = '0; i_sender = 5'b00001;
        tick();
        chk("cont_south_busy", o_free[3], 1'b0);
        set_flit(1, 8'h10);
        i_h = 5'b00010;
        acc = '0;
        for (int k = 0; k < 12; k++) begin
            tick();
            acc |= o_ack_h;
        end
        chk("cont_hold", acc, 5'b0);
        i_sender = '0;
        wait_ack("cont_west", 5'b00010, 5);
        i_h = '0;
        tick();

        // priority / first grant with all requesting
        do_reset();
        for (int p = 0; p < 5; p++) set_flit(p, 8'h11);
        i_h = 5'b11111;
`ifdef PHOENIX_SC_LOCAL_PRIO_EN
        wait_ack("macro_first", 5'b10000, 6);
`else
        wait_ack("macro_first", 5'b00001, 6);
`endif
        i_h = '0;
        tick();

        // reset during ACK
        do_reset();
        set_flit(2, 8'h31);
        i_h = 5'b00100;
        tick(); tick(); tick();
        chk("midrst_in_ack", o_ack_h, 5'b00100);
        i_rst = 1'b0;
        tick();
        chk("midrst_ack", o_ack_h, 5'b0);
        chk("midrst_free", o_free, 5'b11111);
        chk("midrst_mux_in", o_mux_in, 15'h7fff);
        chk("midrst_mux_out", o_mux_out, 15'h7fff);
        i_rst = 1'b1; i_h = '0;
        tick();

        // randomized traffic against the model
        for (int c = 0; c < 2500; c++) begin
            i_h = 5'($urandom_range(0, 31) & $urandom_range(0, 31));
            for (int p = 0; p < 5; p++) begin
                if ($urandom_range(0, 7) == 0) i_sender[p] = ~i_sender[p];
                if ($urandom_range(0, 3) == 0)
                    set_flit(p, {4'($urandom_range(0, 2)), 4'($urandom_range(0, 2))});
            end
            i_rst = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
